reset_seq_gen: RTL and testbench

- Source-side reset generator and sequencer.
- Produces a minimum-width, glitch-free reset for each of STAGES downstream reset domains; those domains re-synchronize it locally.
- Merges power-on, software and watchdog reset requests into one reset.
- Releases the stages one after another in index order, with a fixed gap, and records which sources caused the last reset.

---
 rtl/reset_seq_gen.sv | 81 ++++++++
 tb/tb_reset_seq_gen.sv | 104 ++++++++++
 2 files changed

// File: rtl/reset_seq_gen.sv
// reset_seq_gen: merges power-on/software/watchdog resets and releases STAGES
// reset outputs in index order after a minimum hold, recording the reset cause.
module reset_seq_gen #(
  parameter int HOLD_CYCLES  = 16,
  parameter int STAGES       = 3,
  parameter int STAGE_GAP    = 4,
  parameter int CNT_W        = 8,
  parameter int POLARITY_OUT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sw_rst_req,
  input  logic              wd_rst_req,
  input  logic              cause_clr,
  output logic [STAGES-1:0] rst_out,
  output logic              rst_busy,
  output logic [2:0]        rst_cause
);
  localparam int IW = STAGES > 1 ? $clog2(STAGES) : 1;
  localparam logic [STAGES-1:0] ASSERTED = POLARITY_OUT != 0 ? '1 : '0;
  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [STAGES-1:0] out_n, rel;
  logic [2:0] cause_n;
  logic busy_n, req, term;
  // idx always names the next stage to release, so the HOLD exit and every
  // RELEASE gap share the same release path.
  always_comb begin
    req     = sw_rst_req | wd_rst_req;
    rel     = STAGES'(1) << idx;
    term    = (state == HOLD && cnt == CNT_W'(HOLD_CYCLES - 1)) ||
              (state == RELEASE && cnt == CNT_W'(STAGE_GAP - 1));
    cause_n = (cause_clr ? 3'b000 : rst_cause) | {wd_rst_req, sw_rst_req, 1'b0};
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    out_n   = rst_out;
    busy_n  = rst_busy;
    if (req) begin
      state_n = HOLD;
      cnt_n   = '0;
      idx_n   = '0;
      out_n   = ASSERTED;
      busy_n  = 1'b1;
    end else if (state != RUN) begin
      if (term) begin
        cnt_n = '0;
        out_n = POLARITY_OUT != 0 ? rst_out & ~rel : rst_out | rel;
        if (idx == IW'(STAGES - 1)) begin
          state_n = RUN;
          idx_n   = '0;
          busy_n  = 1'b0;
        end else begin
          state_n = RELEASE;
          idx_n   = idx + IW'(1);
        end
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HOLD;
      cnt       <= '0;
      idx       <= '0;
      rst_out   <= ASSERTED;
      rst_busy  <= 1'b1;
      rst_cause <= 3'b001;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      rst_out   <= out_n;
      rst_busy  <= busy_n;
      rst_cause <= cause_n;
    end
  end
endmodule

// File: tb/tb_reset_seq_gen.sv
// tb_reset_seq_gen: directed and random checks of reset_seq_gen in two
// configurations against a "quiet edges since last reset" reference model.
module tb_reset_seq_gen;
  localparam int H0 = 16, S0 = 3, G0 = 4;
  logic clk = 1'b0, rst_n = 1'b0, sw = 1'b0, wd = 1'b0, clr = 1'b0;
  logic [2:0] out0, cause0, cause1;
  logic [0:0] out1;
  logic busy0, busy1;
  int checks = 0, errors = 0;
  int quiet = 0;
  logic [2:0] cause_m = 3'b001;

  reset_seq_gen u0 (.clk(clk), .rst_n(rst_n), .sw_rst_req(sw), .wd_rst_req(wd),
    .cause_clr(clr), .rst_out(out0), .rst_busy(busy0), .rst_cause(cause0));
  reset_seq_gen #(.HOLD_CYCLES(1), .STAGES(1), .POLARITY_OUT(0)) u1 (.clk(clk),
    .rst_n(rst_n), .sw_rst_req(sw), .wd_rst_req(wd), .cause_clr(clr),
    .rst_out(out1), .rst_busy(busy1), .rst_cause(cause1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A stage i is released once HOLD + i*GAP request-free edges have elapsed.
  task automatic check_all(input string tag);
    logic [2:0] e0;
    for (int i = 0; i < S0; i++) e0[i] = quiet < H0 + i * G0;
    chk({tag, "_out0"}, 32'(out0), 32'(e0));
    chk({tag, "_busy0"}, 32'(busy0), 32'(e0 != 3'b000));
    chk({tag, "_cause0"}, 32'(cause0), 32'(cause_m));
    chk({tag, "_out1"}, 32'(out1), 32'(quiet >= 1));
    chk({tag, "_busy1"}, 32'(busy1), 32'(quiet < 1));
    chk({tag, "_cause1"}, 32'(cause1), 32'(cause_m));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    cause_m = (clr ? 3'b000 : cause_m) | {wd, sw, 1'b0};
    quiet = (sw | wd) ? 0 : (quiet < 1000 ? quiet + 1 : quiet);
    #1;
    check_all(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    #12;
    check_all("por_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(30, "por");
    chk("por_final_out", 32'(out0), 32'(3'b000));
    sw = 1'b1; step("sw_pulse");
    chk("sw_immediate", 32'(out0), 32'(3'b111));
    sw = 1'b0; run(30, "sw_release");
    chk("sw_cause", 32'(cause0), 32'(3'b011));
    sw = 1'b1; step("pre_wd");
    sw = 1'b0; run(17, "pre_wd");
    chk("wd_pre_state", 32'(out0), 32'(3'b110));
    wd = 1'b1; run(10, "wd_held");
    wd = 1'b0; run(35, "wd_release");
    chk("wd_cause", 32'(cause0[2]), 32'(1'b1));
    clr = 1'b1; sw = 1'b1; step("clr_sw");
    chk("clr_sw_cause", 32'(cause0), 32'(3'b010));
    sw = 1'b0; step("clr_alone");
    chk("clr_alone_cause", 32'(cause0), 32'(3'b000));
    clr = 1'b0; run(30, "after_clr");
    rst_n = 1'b0; #1;
    quiet = 0; cause_m = 3'b001;
    check_all("por_restart");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(17, "mid_seq");
    rst_n = 1'b0; #1;
    quiet = 0; cause_m = 3'b001;
    check_all("async_mid");
    chk("async_mid_out", 32'(out0), 32'(3'b111));
    #1 rst_n = 1'b1;
    run(30, "after_async");
    for (int i = 0; i < 400; i++) begin
      sw  = $urandom_range(0, 19) == 0;
      wd  = $urandom_range(0, 29) == 0;
      clr = $urandom_range(0, 14) == 0;
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0; #1;
        quiet = 0; cause_m = 3'b001;
        check_all("rnd_async");
        #1 rst_n = 1'b1;
      end
      step("rnd");
    end
    sw = 1'b0; wd = 1'b0; clr = 1'b0;
    run(30, "drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
